// File: rtl/fnd_bcd_scanner_pkg.sv
// Shared definitions for the FND BCD scanner: blank code, FSM states and a width helper.
package fnd_bcd_scanner_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } fsm_state_e;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/fnd_bcd_scanner_bcd_dd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift left bringing in one bit.
module fnd_bcd_scanner_bcd_dd_step #(
    parameter int unsigned INT_DIG = 3
) (
    input  logic [INT_DIG*4-1:0] acc,
    input  logic                 shift_in,
    output logic [INT_DIG*4-1:0] acc_next
);

    logic [INT_DIG*4-1:0] adj;

    always_comb begin
        adj = acc;
        for (int n = 0; n < int'(INT_DIG); n++) begin
            if (acc[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
            end
        end
        acc_next = {adj[INT_DIG*4-2:0], shift_in};
    end

endmodule

// File: rtl/fnd_bcd_scanner.sv
// Snapshots N_CH binary channels, converts them one bit per cycle to saturated BCD banks,
// and scans the committed digits onto a single FND digit output with leading-zero blanking.
module fnd_bcd_scanner
    import fnd_bcd_scanner_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned N_DIG    = 2,
    parameter int unsigned SCAN_DIV = 100_000,
    localparam int unsigned SEL_W   = clog2(N_CH * N_DIG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*IN_W-1:0]    ch_data,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH*N_DIG*4-1:0] digits,
    output logic [SEL_W-1:0]        sel,
    output logic [3:0]              bcd,
    output logic                    blank
);

    localparam int unsigned N_TOT   = N_CH * N_DIG;
    localparam int unsigned INT_DIG = (IN_W + 2) / 3;
    localparam int unsigned WORK_W  = INT_DIG * 4;
    localparam int unsigned BANK_W  = N_DIG * 4;
    localparam int unsigned EXT_W   = (INT_DIG > N_DIG) ? WORK_W : BANK_W;
    localparam int unsigned CH_W    = clog2(N_CH);
    localparam int unsigned BIT_W   = clog2(IN_W);
    localparam int unsigned CNT_W   = clog2(SCAN_DIV);

    fsm_state_e            state_q, state_d;
    logic [N_CH*IN_W-1:0]  snap_q, snap_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [WORK_W-1:0]     work_q, work_d, work_step;
    logic [N_CH*BANK_W-1:0] stage_q, stage_d, digits_q, digits_d;
    logic [N_CH-1:0]       stage_ovf_q, stage_ovf_d, ovf_q, ovf_d;
    logic                  busy_q, done_q, done_d;

    logic [IN_W-1:0]       cur_ch;
    logic [BIT_W-1:0]      msb_idx;
    logic [EXT_W-1:0]      res_ext;
    logic [BANK_W-1:0]     res_bank;
    logic                  res_ovf;

    always_comb begin
        cur_ch = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (ch_q == CH_W'(k)) cur_ch = snap_q[k*IN_W +: IN_W];
        end
        msb_idx = BIT_W'(IN_W - 1) - bit_q;
    end

    fnd_bcd_scanner_bcd_dd_step #(
        .INT_DIG (INT_DIG)
    ) u_dd_step (
        .acc      (work_q),
        .shift_in (cur_ch[msb_idx]),
        .acc_next (work_step)
    );

    // Anything above the displayed nibbles means the value does not fit: show all 9s.
    always_comb begin
        res_ext  = EXT_W'(work_step);
        res_ovf  = (res_ext >> BANK_W) != '0;
        res_bank = res_ovf ? {N_DIG{4'd9}} : res_ext[BANK_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        ch_d        = ch_q;
        bit_d       = bit_q;
        work_d      = work_q;
        stage_d     = stage_q;
        stage_ovf_d = stage_ovf_q;
        digits_d    = digits_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                // The done cycle still belongs to the previous transaction.
                if (load && !done_q) begin
                    snap_d  = ch_data;
                    ch_d    = '0;
                    bit_d   = '0;
                    work_d  = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                work_d = work_step;
                bit_d  = bit_q + 1'b1;
                if (bit_q == BIT_W'(IN_W - 1)) begin
                    bit_d  = '0;
                    work_d = '0;
                    for (int k = 0; k < int'(N_CH); k++) begin
                        if (ch_q == CH_W'(k)) begin
                            stage_d[k*BANK_W +: BANK_W] = res_bank;
                            stage_ovf_d[k]              = res_ovf;
                        end
                    end
                    if (ch_q == CH_W'(N_CH - 1)) state_d = StCommit;
                    else                         ch_d    = ch_q + 1'b1;
                end
            end
            StCommit: begin
                digits_d = stage_q;
                ovf_d    = stage_ovf_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            snap_q      <= '0;
            ch_q        <= '0;
            bit_q       <= '0;
            work_q      <= '0;
            stage_q     <= '0;
            stage_ovf_q <= '0;
            digits_q    <= '0;
            ovf_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            ch_q        <= ch_d;
            bit_q       <= bit_d;
            work_q      <= work_d;
            stage_q     <= stage_d;
            stage_ovf_q <= stage_ovf_d;
            digits_q    <= digits_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= (state_q != StIdle);
        end
    end

    logic [CNT_W-1:0] psc_q, psc_d;
    logic             tick;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       bcd_q, bcd_d, dig_at;
    logic             blank_q, blank_d, lz_at, zero_run;

    // Display registers are loaded from the next scan index so sel/bcd/blank change together.
    always_comb begin
        tick  = (psc_q == CNT_W'(SCAN_DIV - 1));
        psc_d = tick ? '0 : psc_q + 1'b1;
        sel_d = sel_q;
        if (tick) sel_d = (sel_q == SEL_W'(N_TOT - 1)) ? '0 : sel_q + 1'b1;

        dig_at   = '0;
        lz_at    = 1'b0;
        zero_run = 1'b1;
        for (int k = 0; k < int'(N_CH); k++) begin
            zero_run = 1'b1;
            for (int d = int'(N_DIG) - 1; d >= 0; d--) begin
                zero_run = zero_run && (digits_q[(k*int'(N_DIG)+d)*4 +: 4] == 4'd0);
                if (sel_d == SEL_W'(k*int'(N_DIG) + d)) begin
                    dig_at = digits_q[(k*int'(N_DIG)+d)*4 +: 4];
                    lz_at  = (d > 0) && zero_run;
                end
            end
        end
        blank_d = blank_lz && lz_at;
        bcd_d   = blank_d ? BCD_BLANK : dig_at;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            sel_q   <= '0;
            bcd_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digits = digits_q;
    assign sel    = sel_q;
    assign bcd    = bcd_q;
    assign blank  = blank_q;

endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// Directed bench for fnd_bcd_scanner: a 2x8-bit/2-digit build and a 3x10-bit/4-digit build.
module tb_fnd_bcd_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_load, a_blank_lz, a_busy, a_done, a_blank;
    logic [15:0] a_data, a_digits;
    logic [1:0]  a_ovf, a_sel;
    logic [3:0]  a_bcd;

    logic        b_rst_n, b_load, b_blank_lz, b_busy, b_done, b_blank;
    logic [29:0] b_data;
    logic [2:0]  b_ovf;
    logic [47:0] b_digits;
    logic [3:0]  b_sel, b_bcd;

    fnd_bcd_scanner #(
        .N_CH(2), .IN_W(8), .N_DIG(2), .SCAN_DIV(4)
    ) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .ch_data(a_data), .load(a_load), .blank_lz(a_blank_lz),
        .busy(a_busy), .done(a_done), .ovf(a_ovf), .digits(a_digits), .sel(a_sel),
        .bcd(a_bcd), .blank(a_blank)
    );

    fnd_bcd_scanner #(
        .N_CH(3), .IN_W(10), .N_DIG(4), .SCAN_DIV(4)
    ) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .ch_data(b_data), .load(b_load), .blank_lz(b_blank_lz),
        .busy(b_busy), .done(b_done), .ovf(b_ovf), .digits(b_digits), .sel(b_sel),
        .bcd(b_bcd), .blank(b_blank)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lat, pulses, moves, guard;
    logic b1, b17, b18, wrapped;
    logic [1:0] prev_a, next_a;
    logic [3:0] prev_b, next_b;

    logic [3:0] exp_b_bcd   [12] = '{4'd3, 4'd2, 4'd0, 4'd1, 4'd0, 4'hF, 4'hF, 4'hF,
                                     4'd9, 4'd9, 4'd9, 4'hF};
    logic       exp_b_blank [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load temp/humid and watch 40 cycles; extra load pulses at cycles p1/p2 with junk data.
    task automatic conv_a(input logic [7:0] t, input logic [7:0] h, input int p1, input int p2);
        @(negedge clk);
        a_data = {h, t};
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        lat    = -1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)  b1  = a_busy;
            if (k == 17) b17 = a_busy;
            if (k == 18) b18 = a_busy;
            if (a_done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            a_load = (k == p1) || (k == p2);
            if (a_load) a_data = 16'h9999;
        end
        a_load = 1'b0;
    endtask

    task automatic check_conv_a(input string tag, input logic [15:0] dig, input logic [1:0] ov);
        check_eq({tag, "_done_lat"}, 64'(lat), 64'd17);
        check_eq({tag, "_done_cnt"}, 64'(pulses), 64'd1);
        check_eq({tag, "_digits"}, a_digits, dig);
        check_eq({tag, "_ovf"}, a_ovf, ov);
    endtask

    task automatic scan_a(input string tag, input logic [1:0] s, input logic [3:0] eb,
                          input logic ebl);
        int g;
        g = 0;
        repeat (2) @(negedge clk);
        while (a_sel != s && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_eq({tag, "_reach"}, g < 100, 1'b1);
        check_eq({tag, "_bcd"}, a_bcd, eb);
        check_eq({tag, "_blank"}, a_blank, ebl);
    endtask

    initial begin
        a_rst_n = 0; b_rst_n = 0; a_load = 0; b_load = 0;
        a_blank_lz = 0; b_blank_lz = 0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", a_busy, 1'b0);
        check_eq("rst_done", a_done, 1'b0);
        check_eq("rst_ovf", a_ovf, 2'b00);
        check_eq("rst_digits", a_digits, 16'h0);
        check_eq("rst_sel", a_sel, 2'd0);
        check_eq("rst_bcd", a_bcd, 4'd0);
        check_eq("rst_blank", a_blank, 1'b0);
        check_eq("rst_b_digits", b_digits, 48'h0);
        a_rst_n = 1; b_rst_n = 1;

        // 25 / 63
        conv_a(8'd25, 8'd63, 0, 0);
        check_conv_a("t1", 16'h6325, 2'b00);
        check_eq("t1_busy_c1", b1, 1'b1);
        check_eq("t1_busy_commit", b17, 1'b1);
        check_eq("t1_busy_after", b18, 1'b0);
        prev_a = a_sel;
        moves  = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (a_sel != prev_a) begin
                next_a = prev_a + 2'd1;
                check_eq("t1_sel_step", a_sel, next_a);
                prev_a = a_sel;
                moves++;
            end
        end
        check_eq("t1_sel_moves", 64'(moves), 64'd6);
        scan_a("t1_s0", 2'd0, 4'd5, 1'b0);
        scan_a("t1_s1", 2'd1, 4'd2, 1'b0);
        scan_a("t1_s2", 2'd2, 4'd3, 1'b0);
        scan_a("t1_s3", 2'd3, 4'd6, 1'b0);

        // 7 / 100 saturates humidity, leading zero blanking on temperature
        a_blank_lz = 1'b1;
        conv_a(8'd7, 8'd100, 0, 0);
        check_conv_a("t2", 16'h9907, 2'b10);
        scan_a("t2_s0", 2'd0, 4'd7, 1'b0);
        scan_a("t2_s1", 2'd1, 4'hF, 1'b1);
        scan_a("t2_s2", 2'd2, 4'd9, 1'b0);
        scan_a("t2_s3", 2'd3, 4'd9, 1'b0);
        a_blank_lz = 1'b0;
        scan_a("t3_s1", 2'd1, 4'd0, 1'b0);

        // zero on a channel: ones digit shown, tens blanked
        a_blank_lz = 1'b1;
        conv_a(8'd0, 8'd63, 0, 0);
        check_conv_a("t3z", 16'h6300, 2'b00);
        scan_a("t3z_s0", 2'd0, 4'd0, 1'b0);
        scan_a("t3z_s1", 2'd1, 4'hF, 1'b1);
        a_blank_lz = 1'b0;

        // loads during conversion and during the done cycle are dropped
        conv_a(8'd42, 8'd18, 3, 16);
        check_conv_a("t4", 16'h1842, 2'b00);
        conv_a(8'd11, 8'd22, 17, 0);
        check_conv_a("t4d", 16'h2211, 2'b00);
        check_eq("t4d_busy_idle", a_busy, 1'b0);

        // reset mid-conversion
        conv_a(8'd7, 8'd100, 0, 0);
        @(negedge clk);
        a_data = {8'd66, 8'd55};
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
        repeat (8) @(negedge clk);
        a_rst_n = 1'b0;
        #1;
        check_eq("t5_busy", a_busy, 1'b0);
        check_eq("t5_done", a_done, 1'b0);
        check_eq("t5_ovf", a_ovf, 2'b00);
        check_eq("t5_digits", a_digits, 16'h0);
        check_eq("t5_sel", a_sel, 2'd0);
        check_eq("t5_bcd", a_bcd, 4'd0);
        check_eq("t5_blank", a_blank, 1'b0);
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_done) pulses++;
        end
        check_eq("t5_no_done", 64'(pulses), 64'd0);
        conv_a(8'd12, 8'd34, 0, 0);
        check_conv_a("t5r", 16'h3412, 2'b00);

        // 3 channels x 10 bits x 4 digits
        b_blank_lz = 1'b1;
        @(negedge clk);
        b_data = {10'd999, 10'd0, 10'd1023};
        b_load = 1'b1;
        @(negedge clk);
        b_load = 1'b0;
        lat    = -1;
        pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (b_done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        check_eq("t6_done_lat", 64'(lat), 64'd31);
        check_eq("t6_done_cnt", 64'(pulses), 64'd1);
        check_eq("t6_digits", b_digits, 48'h0999_0000_1023);
        check_eq("t6_ovf", b_ovf, 3'b000);
        prev_b  = b_sel;
        moves   = 0;
        wrapped = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b_sel != prev_b) begin
                next_b = (prev_b == 4'd11) ? 4'd0 : prev_b + 4'd1;
                check_eq("t6_sel_step", b_sel, next_b);
                if (prev_b == 4'd11) wrapped = 1'b1;
                prev_b = b_sel;
                moves++;
            end
        end
        check_eq("t6_sel_moves", 64'(moves), 64'd15);
        check_eq("t6_sel_wrap", wrapped, 1'b1);
        for (int s = 0; s < 12; s++) begin
            guard = 0;
            while (b_sel != 4'(s) && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_eq("t6_reach", guard < 100, 1'b1);
            check_eq("t6_bcd", b_bcd, exp_b_bcd[s]);
            check_eq("t6_blank", b_blank, exp_b_blank[s]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_bcd_scanner.md
# fnd_bcd_scanner

Parametrised successor to the DHT11 digit split/mux path. It snapshots N_CH unsigned binary channels on a load pulse and converts them sequentially with an iterative double-dabble engine instead of combinational divide/modulo. Results are held in registered BCD digit banks with overflow saturation. A free-running scan drives the FND mux with optional leading-zero blanking, and sits between the sensor/controller blocks and the FND decoder/anode driver.

## Interface
- N_CH, 2: number of binary channels (≥1); channel 0 = temperature, channel 1 = humidity in the DHT11 build
- IN_W, 8: bits per channel (≥2)
- N_DIG, 2: displayed BCD digits per channel (≥1)
- SCAN_DIV, 100_000: clk cycles per scan step (≥2)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_data  in  N_CH*IN_W  packed channels, channel k at [k*IN_W +: IN_W]
- load  in  1  single-cycle request to snapshot and convert all channels
- blank_lz  in  1  1 = blank leading zeros on the scanned output
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when all digit banks have updated
- ovf  out  N_CH  per-channel flag: last converted value ≥ 10^N_DIG
- digits  out  N_CH*N_DIG*4  packed BCD banks, digit index i = k*N_DIG + d at [i*4 +: 4], d=0 is ones
- sel  out  clog2(N_CH*N_DIG) (min 1)  currently scanned digit index
- bcd  out  4  scanned digit value; 4'hF when blanked
- blank  out  1  scanned digit is blanked

## Operation
- FSM states are IDLE, CONV, COMMIT.
- IDLE: `load`=1 → latch `ch_data` into a snapshot register, set channel counter to 0, bit counter to 0, clear the working BCD shift register → CONV.
- CONV: one double-dabble step per cycle, on the current channel's snapshot. The step adds 3 to each working nibble ≥5, then shifts left 1, bringing in the next input MSB.
  - Working width: INT_DIG = (IN_W+2)/3 nibbles, which is always sufficient.
  - After IN_W steps, the lower N_DIG nibbles go to a staging bank for that channel.
  - ovf_stage[k] = any upper nibble (index ≥ N_DIG) nonzero. If set, the staged digits saturate to all 9s.
  - Counters then advance to the next channel. After the last channel → COMMIT.
- COMMIT: copy all staging banks to `digits` and staging ovf to `ovf` in one cycle, pulse `done` → IDLE. Displayed values never show a partial update.
- `load` while not IDLE is ignored; there is no queuing.
- `ch_data` changes after the load cycle have no effect on the conversion in progress.
- Scan:
  - Free-running prescaler counts 0..SCAN_DIV-1. Its terminal count is `tick`.
  - On `tick`, the scan index advances and wraps from N_CH*N_DIG-1 to 0.
  - The scan runs independently of the FSM.
- Blanking: digit (k,d) with d>0 is blanked iff blank_lz=1 and digits d..N_DIG-1 of channel k are all 0. The ones digit (d=0) is never blanked. `blank_lz`=0 → `blank` is always 0.

## Timing
- Reset values: `busy`=0, `done`=0, `ovf`=0, `digits`=0, `sel`=0, `bcd`=0, `blank`=0, FSM=IDLE, prescaler=0.
- Reset mid-conversion aborts the conversion. `digits` return to 0, and the pre-reset `done` is never asserted.
- Load accepted on edge c:
  - `busy`=1 from c+1 through the COMMIT cycle.
  - `done`=1 for exactly one cycle at c+N_CH*IN_W+1. `digits`/`ovf` show new values in that same cycle.
  - `busy`=0 at c+N_CH*IN_W+2. A new load is accepted in that cycle.
- `load` coincident with the `done` cycle is ignored.
- Scan outputs are registered. `sel`, `bcd` and `blank` update the cycle after `tick` and are mutually consistent.
- `bcd`/`blank` reflect committed `digits` with one cycle of latency. A commit between ticks updates the shown digit within one cycle.
- With N_CH*N_DIG a power of two, `sel` wraps naturally. Otherwise it wraps explicitly.

## Structure
- Shared header `fnd_defs.vh`:
  - BCD_BLANK = 4'hF
  - clog2 function
  - FSM state encodings IDLE/CONV/COMMIT
- Sub-module `bcd_dd_step`: combinational add-3 and shift of an INT_DIG-nibble register plus one input bit. It is instantiated once and shared across channels by the FSM.
- Scan/blank logic stays in the top level.

## Test plan
- Reset, then N_CH=2, IN_W=8, N_DIG=2: load temp=25, humid=63. Required: `done` 17 cycles after load; `digits`=0x6325; `ovf`=0; `sel` cycles 0→1→2→3→0 giving `bcd` 5, 2, 3, 6 per tick.
- Load temp=7, humid=100 with blank_lz=1. Required: humid digits=9,9 and ovf=2'b10; temp ones `bcd`=7; temp tens `blank`=1, `bcd`=4'hF.
- Same data with blank_lz=0: `blank` stays 0 and temp tens shows `bcd`=0. Also load 0 on a channel: its ones digit shows 0 and is unblanked.
- Pulse `load` again at cycles 3 and 16 after an accepted load: both are ignored. Only one `done`; `digits` unchanged from the first snapshot even though `ch_data` changed.
- Assert rst_n=0 at cycle 8 of a conversion: all outputs return to reset values and no `done` follows. A load after release converts normally.
- IN_W=10, N_DIG=4, N_CH=3, SCAN_DIV=4: load 1023, 0, 999. Required: digits 1023/0000/0999, `done` at cycle 31, `sel` wraps from 11 to 0, and leading zeros are blanked per channel.
